// File: rtl/coincidence_window_controller.sv
// Timed integration windows for a two-fold coincidence counter: counts rising edges
// on A, B and A&B per window and hands the totals to readout via valid/ready.
module coincidence_window_controller #(
  parameter int CNT_W = 32,
  parameter int WIN_W = 32,
  parameter int IDX_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [WIN_W-1:0] window_len,
  input  logic             click_a,
  input  logic             click_b,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_a,
  output logic [CNT_W-1:0] res_b,
  output logic [CNT_W-1:0] res_ab,
  output logic [IDX_W-1:0] res_idx,
  output logic             overrun
);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state;
  logic [2:0]       lvl;
  logic [2:0]       lvl_q;
  logic [2:0]       ev;
  logic [WIN_W-1:0] len_r;
  logic [WIN_W-1:0] win_cnt;
  logic             cont_r;
  logic [IDX_W-1:0] win_idx;
  logic             arm;
  logic             abort;
  logic             last;
  logic             produce;
  logic             clear_win;
  logic             accept;
  logic [CNT_W-1:0] cnt_sum [3];

  // Channel order: 0 = A, 1 = B, 2 = coincidence A&B.
  assign lvl       = {click_a & click_b, click_b, click_a};
  assign ev        = lvl & ~lvl_q;
  assign arm       = (state == IDLE) && start && !stop;
  assign abort     = (state == COUNT) && stop;
  assign last      = (state == COUNT) && (win_cnt == len_r - WIN_W'(1));
  assign produce   = last && !stop;
  assign clear_win = arm || abort || last;
  assign accept    = res_valid && res_ready;

  // cnt_sum already includes this cycle's event, so the final cycle's edge lands in its own window.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt;

      assign cnt_sum[gi] = (&cnt) ? cnt : cnt + CNT_W'(ev[gi]);

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt <= '0;
        end else if (clear_win) begin
          cnt <= '0;
        end else if (state == COUNT) begin
          cnt <= cnt_sum[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      lvl_q     <= '0;
      len_r     <= '0;
      cont_r    <= 1'b0;
      win_cnt   <= '0;
      win_idx   <= '0;
      res_valid <= 1'b0;
      res_a     <= '0;
      res_b     <= '0;
      res_ab    <= '0;
      res_idx   <= '0;
      overrun   <= 1'b0;
    end else begin
      lvl_q <= lvl;

      case (state)
        IDLE: begin
          if (arm) begin
            state   <= COUNT;
            busy    <= 1'b1;
            len_r   <= (window_len == '0) ? WIN_W'(1) : window_len;
            cont_r  <= continuous;
            win_cnt <= '0;
            win_idx <= '0;
            res_idx <= '0;
            overrun <= 1'b0;
          end
        end
        COUNT: begin
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            win_cnt <= '0;
          end else if (last) begin
            win_cnt <= '0;
            win_idx <= win_idx + IDX_W'(1);
            if (!cont_r) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A new result beats a same-cycle acceptance; it only counts as overrun if nobody took the old one.
      if (produce) begin
        res_a     <= cnt_sum[0];
        res_b     <= cnt_sum[1];
        res_ab    <= cnt_sum[2];
        res_idx   <= win_idx;
        res_valid <= 1'b1;
        if (res_valid && !res_ready) begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
